and_or_bist_ctrl: RTL and testbench
===================================

Name: and_or_bist_ctrl

Overview:
Built-in self-test sequencer for the (A AND B) OR C gate. On request it drives all eight input vectors into the gate in order, waits a configurable settle time and compares Q against an internally computed expected value. It counts mismatches, captures the first failing vector and reports pass/fail with a start/busy/done handshake. It sits between a test host (bench, switch panel or CPU register) and one gate instance.

Parameters:
SETTLE_CYC, 1, WAIT-state cycles between driving a vector and sampling Q; legal range 1..15.
PASSES, 1, number of full 8-vector sweeps per run; legal range 1..15.
ERR_W, 4, width of the saturating mismatch counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  level; sampled only in IDLE.
abort  input  1  level; terminates a run in progress.
dut_a  output  1  gate input A; registered.
dut_b  output  1  gate input B; registered.
dut_c  output  1  gate input C; registered.
dut_q  input  1  gate output Q.
busy  output  1  high while a run is in progress.
done  output  1  one-cycle pulse at normal completion.
pass  output  1  1 when the last completed run had zero mismatches; held until the next start.
err_cnt  output  ERR_W  saturating mismatch count for the current or last run.
ff_valid  output  1  set when a first failure has been captured.
ff_vec  output  3  {A,B,C} of the first failing vector.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n=0 every output is 0 and the state is IDLE. Reset asserted mid-run aborts the run immediately; no done pulse is produced.
- Vector register: vec[2:0] drives {dut_a,dut_b,dut_c} = vec. It is 000 in IDLE and DONE.
- Expected value: exp = (vec[2] & vec[1]) | vec[0].
- States: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE:
  - start=1 and abort=0 → APPLY.
  - On that edge: vec=0, sweep=0, err_cnt=0, ff_valid=0, ff_vec=0, pass=0, busy=1.
- APPLY: 1 cycle with vec driven → WAIT; load the settle counter with SETTLE_CYC.
- WAIT: count down. On reaching the last cycle → CHECK. Occupies exactly SETTLE_CYC cycles.
- CHECK: 1 cycle; sample dut_q.
  - If dut_q != exp: err_cnt += 1, saturating at 2^ERR_W-1.
  - If dut_q != exp and ff_valid=0: ff_vec=vec and ff_valid=1.
  - Next state:
    - vec<7 → vec+1, go to APPLY.
    - vec=7 and sweep<PASSES-1 → vec=0, sweep+1, go to APPLY.
    - Otherwise → DONE.
- DONE: 1 cycle.
  - done=1, busy=0, pass=(err_cnt==0), vec=0.
  - The error check of the final CHECK is included in pass.
  - → IDLE.
- Timing: each vector takes SETTLE_CYC+2 cycles. busy is high for exactly 8*PASSES*(SETTLE_CYC+2) cycles. done rises on the edge where busy falls.
- start held high: after DONE the FSM returns to IDLE, so a new run starts the cycle after done. start is ignored while busy.
- abort=1 in APPLY, WAIT or CHECK:
  - → IDLE on the next edge; busy=0, no done, pass=0, vec=0.
  - err_cnt, ff_valid and ff_vec keep their values. The CHECK in that same cycle is discarded.
- start=1 and abort=1 together in IDLE: abort wins and the FSM stays in IDLE.
- Results (err_cnt, ff_*, pass) are stable in IDLE until the next accepted start.

Test Plan:
1. Correct gate, defaults: pulse start → busy high 24 cycles; vectors 000..111 in order, each held 3 cycles; done one pulse; pass=1, err_cnt=0, ff_valid=0.
2. Q stuck-at-0 model → err_cnt=5 (vectors 001, 011, 101, 110, 111), ff_vec=001, ff_valid=1, pass=0.
3. Q stuck-at-1, PASSES=2, SETTLE_CYC=3 → busy 80 cycles, err_cnt=6, ff_vec=000, pass=0.
4. Saturation, ERR_W=3, PASSES=2, stuck-at-0 → err_cnt=7 (not 10), pass=0.
5. Abort in WAIT of vector 4 with the stuck-at-0 model → IDLE next edge, no done, busy=0, err_cnt=2, ff_vec=001. Then abort and start together → stays IDLE.
6. rst_n low mid-sweep → all outputs 0 asynchronously. After release, start → a full clean run completes with pass=1. Holding start high through done → a second run starts the cycle after done.

Source files
------------

// File: rtl/and_or_bist_ctrl.sv
// BIST sequencer for one (A AND B) OR C gate: sweeps all eight input vectors,
// compares Q after a settle delay, and reports mismatch count, first failure and pass/fail.
module and_or_bist_ctrl #(
  parameter int SETTLE_CYC = 1,
  parameter int PASSES     = 1,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_c,
  input  logic             dut_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             ff_valid,
  output logic [2:0]       ff_vec,
  output logic [2:0]       state_dbg
);

  // Handshake: start is a level accepted only in IDLE (abort has priority);
  // busy spans the whole run and done pulses for one cycle as busy falls.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_APPLY = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0]       SETTLE_LD  = 4'(SETTLE_CYC);
  localparam logic [3:0]       LAST_SWEEP = 4'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;
  localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);

  logic [2:0]       state;
  logic [2:0]       vec;
  logic [3:0]       settle_cnt;
  logic [3:0]       sweep;
  logic             exp_bit;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  assign {dut_a, dut_b, dut_c} = vec;
  assign state_dbg             = state;

  always_comb begin
    exp_bit  = (vec[2] & vec[1]) | vec[0];
    mismatch = (state == S_CHECK) && (dut_q != exp_bit);
    err_next = err_cnt;
    if (mismatch && (err_cnt != ERR_MAX)) err_next = err_cnt + ERR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      vec        <= 3'd0;
      settle_cnt <= 4'd0;
      sweep      <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      ff_valid   <= 1'b0;
      ff_vec     <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            state    <= S_APPLY;
            vec      <= 3'd0;
            sweep    <= 4'd0;
            err_cnt  <= '0;
            ff_valid <= 1'b0;
            ff_vec   <= 3'd0;
            pass     <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_APPLY, S_WAIT, S_CHECK: begin
          if (abort) begin
            // Results gathered so far are kept; the in-flight check is dropped.
            state <= S_IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
            vec   <= 3'd0;
          end else if (state == S_APPLY) begin
            state      <= S_WAIT;
            settle_cnt <= SETTLE_LD;
          end else if (state == S_WAIT) begin
            if (settle_cnt <= 4'd1) state <= S_CHECK;
            else settle_cnt <= settle_cnt - 4'd1;
          end else begin
            err_cnt <= err_next;
            if (mismatch && !ff_valid) begin
              ff_valid <= 1'b1;
              ff_vec   <= vec;
            end
            if (vec != 3'd7) begin
              vec   <= vec + 3'd1;
              state <= S_APPLY;
            end else if (sweep != LAST_SWEEP) begin
              vec   <= 3'd0;
              sweep <= sweep + 4'd1;
              state <= S_APPLY;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= (err_next == '0);
              vec   <= 3'd0;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_or_bist_ctrl.sv
// Bench for and_or_bist_ctrl: three parameterisations driven with fault masks on a gate model,
// checked against run-level expectations derived from the mask.
module tb_and_or_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic [2:0] start_v, abort_v, a_v, b_v, c_v, q_v;
  logic [2:0] busy_v, done_v, pass_v, ffv_v;
  logic [3:0] err0, err1;
  logic [2:0] err2;
  logic [2:0] ffvec0, ffvec1, ffvec2;
  logic [2:0] st0, st1, st2;
  logic [7:0] mask [3];

  int s_cyc  [3] = '{1, 3, 2};
  int n_pass [3] = '{1, 2, 2};
  int err_w  [3] = '{4, 4, 3};

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  // gate model: correct function with per-vector output inversions from mask
  always_comb begin
    q_v = '0;
    for (int i = 0; i < 3; i++)
      q_v[i] = ((a_v[i] & b_v[i]) | c_v[i]) ^ mask[i][{a_v[i], b_v[i], c_v[i]}];
  end

  and_or_bist_ctrl #(.SETTLE_CYC(1), .PASSES(1), .ERR_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .dut_a(a_v[0]), .dut_b(b_v[0]), .dut_c(c_v[0]), .dut_q(q_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err0),
    .ff_valid(ffv_v[0]), .ff_vec(ffvec0), .state_dbg(st0));

  and_or_bist_ctrl #(.SETTLE_CYC(3), .PASSES(2), .ERR_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .dut_a(a_v[1]), .dut_b(b_v[1]), .dut_c(c_v[1]), .dut_q(q_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err1),
    .ff_valid(ffv_v[1]), .ff_vec(ffvec1), .state_dbg(st1));

  and_or_bist_ctrl #(.SETTLE_CYC(2), .PASSES(2), .ERR_W(3)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
    .dut_a(a_v[2]), .dut_b(b_v[2]), .dut_c(c_v[2]), .dut_q(q_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_cnt(err2),
    .ff_valid(ffv_v[2]), .ff_vec(ffvec2), .state_dbg(st2));

  function automatic logic [3:0] get_err(input int i);
    case (i)
      0:       return err0;
      1:       return err1;
      default: return {1'b0, err2};
    endcase
  endfunction

  function automatic logic [2:0] get_ffvec(input int i);
    case (i)
      0:       return ffvec0;
      1:       return ffvec1;
      default: return ffvec2;
    endcase
  endfunction

  function automatic logic [2:0] get_st(input int i);
    case (i)
      0:       return st0;
      1:       return st1;
      default: return st2;
    endcase
  endfunction

  function automatic logic [2:0] get_vec(input int i);
    return {a_v[i], b_v[i], c_v[i]};
  endfunction

  // reference model: whole-run results straight from the fault mask
  function automatic int exp_errs(input int i);
    int pc = 0;
    int e, lim;
    for (int v = 0; v < 8; v++) pc += int'(mask[i][v]);
    e   = pc * n_pass[i];
    lim = (1 << err_w[i]) - 1;
    return (e > lim) ? lim : e;
  endfunction

  function automatic int exp_ff(input int i);
    for (int v = 0; v < 8; v++) if (mask[i][v]) return v;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input int i, input string tag);
    check({tag, "_busy"}, 32'(busy_v[i]), 0);
    check({tag, "_done"}, 32'(done_v[i]), 0);
    check({tag, "_pass"}, 32'(pass_v[i]), 0);
    check({tag, "_err"},  32'(get_err(i)), 0);
    check({tag, "_ffv"},  32'(ffv_v[i]), 0);
    check({tag, "_ffvec"}, 32'(get_ffvec(i)), 0);
    check({tag, "_vec"},  32'(get_vec(i)), 0);
    check({tag, "_st"},   32'(get_st(i)), 0);
  endtask

  // driver: one-cycle start pulse; returns at the first busy sample
  task automatic start_run(input int i);
    @(negedge clk);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    check($sformatf("busy_rise%0d", i), 32'(busy_v[i]), 1);
  endtask

  // scoreboard for one run, starting at its first busy cycle
  task automatic watch_run(input int i);
    logic [2:0] exp_q[$];
    int cyc = 0;
    int total;
    for (int p = 0; p < n_pass[i]; p++)
      for (int v = 0; v < 8; v++)
        for (int r = 0; r < s_cyc[i] + 2; r++) exp_q.push_back(3'(v));
    total = exp_q.size();
    while (busy_v[i] && cyc < 2000) begin
      if (exp_q.size() > 0) check($sformatf("vec%0d_c%0d", i, cyc), 32'(get_vec(i)), 32'(exp_q.pop_front()));
      else check($sformatf("busy_over%0d", i), cyc, total);
      check($sformatf("done_early%0d", i), 32'(done_v[i]), 0);
      cyc++;
      @(negedge clk);
    end
    check($sformatf("busy_len%0d", i), cyc, total);
    check($sformatf("done_pulse%0d", i), 32'(done_v[i]), 1);
    check($sformatf("vec_done%0d", i), 32'(get_vec(i)), 0);
    check($sformatf("err%0d", i), 32'(get_err(i)), exp_errs(i));
    check($sformatf("ffv%0d", i), 32'(ffv_v[i]), 32'(mask[i] != 8'h00));
    check($sformatf("ffvec%0d", i), 32'(get_ffvec(i)), exp_ff(i));
    check($sformatf("pass%0d", i), 32'(pass_v[i]), 32'(exp_errs(i) == 0));
    @(negedge clk);
    check($sformatf("done_fall%0d", i), 32'(done_v[i]), 0);
    check($sformatf("idle_busy%0d", i), 32'(busy_v[i]), 0);
    check($sformatf("pass_hold%0d", i), 32'(pass_v[i]), 32'(exp_errs(i) == 0));
  endtask

  initial begin
    int idx;
    rst_n   = 1'b0;
    start_v = '0;
    abort_v = '0;
    for (int i = 0; i < 3; i++) mask[i] = 8'h00;
    #12;
    for (int i = 0; i < 3; i++) check_zero(i, $sformatf("rst%0d", i));
    @(negedge clk);
    rst_n = 1'b1;

    // clean gate, defaults
    start_run(0);
    watch_run(0);

    // Q stuck-at-0: inverted exactly where the correct output is 1
    mask[0] = 8'hEA;
    start_run(0);
    watch_run(0);

    // Q stuck-at-1, two passes, settle 3
    mask[1] = 8'h15;
    start_run(1);
    watch_run(1);

    // saturation with a 3-bit counter
    mask[2] = 8'hEA;
    start_run(2);
    watch_run(2);

    // random fault patterns
    for (int r = 0; r < 6; r++) begin
      idx = $urandom_range(0, 2);
      mask[idx] = 8'($urandom_range(0, 255));
      start_run(idx);
      watch_run(idx);
    end

    // abort during WAIT of vector 4 (busy sample 13 with settle 1)
    mask[0] = 8'hEA;
    start_run(0);
    repeat (13) @(negedge clk);
    check("abort_point_vec", 32'(get_vec(0)), 4);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    check("abort_busy", 32'(busy_v[0]), 0);
    check("abort_done", 32'(done_v[0]), 0);
    check("abort_err", 32'(get_err(0)), 2);
    check("abort_ffv", 32'(ffv_v[0]), 1);
    check("abort_ffvec", 32'(get_ffvec(0)), 1);
    check("abort_pass", 32'(pass_v[0]), 0);
    check("abort_vec", 32'(get_vec(0)), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_quiet_done%0d", k), 32'(done_v[0]), 0);
      check($sformatf("abort_quiet_busy%0d", k), 32'(busy_v[0]), 0);
    end
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("both_busy%0d", k), 32'(busy_v[0]), 0);
      check($sformatf("both_err%0d", k), 32'(get_err(0)), 2);
      check($sformatf("both_ffvec%0d", k), 32'(get_ffvec(0)), 1);
    end
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;

    // asynchronous reset mid-sweep
    start_run(0);
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero(0, "midrst");
    @(negedge clk);
    rst_n = 1'b1;
    mask[0] = 8'h00;
    start_run(0);
    watch_run(0);

    // start held high: back-to-back runs
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    check("hold_busy_rise", 32'(busy_v[0]), 1);
    watch_run(0);
    @(negedge clk);
    check("hold_restart", 32'(busy_v[0]), 1);
    start_v[0] = 1'b0;
    watch_run(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
